// File: rtl/imem_arbiter.sv
// Two-port instruction-ROM arbiter: fetch has priority, debug wins after STARVE_LIMIT lost cycles.
// Single-cycle registered response per port; misaligned grants return err with zero data.
module imem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_dout
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_err_q, if_err_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;
    logic          dbg_err_q, dbg_err_d;

    logic          starve_at_limit;
    logic [31:0]   gnt_addr;
    logic          misaligned;
    logic [31:0]   resp_data;

    assign starve_at_limit = (starve_cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        if_gnt       = 1'b0;
        dbg_gnt      = 1'b0;
        gnt_addr     = if_addr;
        rom_addr     = 32'h0;
        misaligned   = 1'b0;
        resp_data    = 32'h0;
        starve_cnt_d = '0;

        // Grants are gated by rst_n so nothing is issued while reset is asserted.
        if (rst_n) begin
            if (if_req && dbg_req) begin
                if (starve_at_limit) dbg_gnt = 1'b1;
                else                 if_gnt  = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end

        if (dbg_gnt) gnt_addr = dbg_addr;
        if (if_gnt || dbg_gnt) rom_addr = {2'b00, gnt_addr[31:2]};
        misaligned = (gnt_addr[1:0] != 2'b00);
        resp_data  = misaligned ? 32'h0 : rom_dout;

        if (dbg_req && !dbg_gnt) begin
            starve_cnt_d = starve_at_limit ? starve_cnt_q : starve_cnt_q + CW'(1);
        end
    end

    always_comb begin
        if_rvalid_d  = if_gnt;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        dbg_rvalid_d = dbg_gnt;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_err_d    = dbg_err_q;
        // Data and err only move on a grant; otherwise they hold for the requester.
        if (if_gnt) begin
            if_rdata_d = resp_data;
            if_err_d   = misaligned;
        end
        if (dbg_gnt) begin
            dbg_rdata_d = resp_data;
            dbg_err_d   = misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            if_err_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= 32'h0;
            dbg_err_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_imem_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dbg_req;
    logic [31:0] if_addr, dbg_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic [31:0] rom_addr, rom_dout;

    logic [31:0] rom [64];
    exp_t        q_if[$];
    exp_t        q_dbg[$];
    logic [31:0] last_rd [2];
    logic        last_err [2];
    string       pn [2] = '{"if", "dbg"};
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    imem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hC000_0000 | 32'(i);
        rom[2] = 32'h2010_0001;
    end
    assign rom_dout = (rom_addr < 32'd64) ? rom[rom_addr[5:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] rd, input logic e);
        exp_t h;
        bit   due;
        due = 1'b0;
        if (p == 0 && q_if.size() > 0 && q_if[0].cyc == cyc) begin
            h = q_if.pop_front();
            due = 1'b1;
        end
        if (p == 1 && q_dbg.size() > 0 && q_dbg[0].cyc == cyc) begin
            h = q_dbg.pop_front();
            due = 1'b1;
        end
        if (due) begin
            chk({pn[p], "_rvalid"}, 32'(v), 32'd1);
            chk({pn[p], "_rdata"}, rd, h.rd);
            chk({pn[p], "_err"}, 32'(e), 32'(h.err));
            last_rd[p]  = h.rd;
            last_err[p] = h.err;
        end else begin
            chk({pn[p], "_rvalid_idle"}, 32'(v), 32'd0);
            chk({pn[p], "_rdata_hold"}, rd, last_rd[p]);
            chk({pn[p], "_err_hold"}, 32'(e), 32'(last_err[p]));
        end
    endtask

    // Reset discards any in-flight expectation and returns the held values to zero.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_if.delete();
            q_dbg.delete();
            for (int i = 0; i < 2; i++) begin
                last_rd[i]  = 32'h0;
                last_err[i] = 1'b0;
            end
        end else begin
            mon(0, if_rvalid, if_rdata, if_err);
            mon(1, dbg_rvalid, dbg_rdata, dbg_err);
        end
    end

    task automatic apply(input logic ireq, input logic [31:0] ia, input logic dreq,
                         input logic [31:0] da, input logic eg_i, input logic eg_d,
                         input logic [31:0] erom, input logic [31:0] erd, input logic eerr);
        if_req = ireq; if_addr = ia; dbg_req = dreq; dbg_addr = da;
        #3;
        chk("if_gnt", 32'(if_gnt), 32'(eg_i));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(eg_d));
        chk("rom_addr", rom_addr, erom);
        if (eg_i) q_if.push_back('{cyc + 1, erd, eerr});
        if (eg_d) q_dbg.push_back('{cyc + 1, erd, eerr});
    endtask

    task automatic cycle(input logic ireq, input logic [31:0] ia, input logic dreq,
                         input logic [31:0] da, input logic eg_i, input logic eg_d,
                         input logic [31:0] erom, input logic [31:0] erd, input logic eerr);
        @(posedge clk);
        #1;
        apply(ireq, ia, dreq, da, eg_i, eg_d, erom, erd, eerr);
    endtask

    task automatic chk_reset_outs();
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_if_err", 32'(if_err), 32'd0);
        chk("rst_dbg_err", 32'(dbg_err), 32'd0);
    endtask

    localparam logic [31:0] FA = 32'h0000_0010;   // word 4
    localparam logic [31:0] DA = 32'h0000_0020;   // word 8
    localparam logic [31:0] FW = 32'hC000_0004;
    localparam logic [31:0] DW = 32'hC000_0008;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; dbg_req = 1'b0; if_addr = 32'h0; dbg_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1 if_req = 1'b1; dbg_req = 1'b1; if_addr = 32'h8; dbg_addr = 32'h6;
        #3 chk_reset_outs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Grant in the very first cycle after release.
        apply(1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2, 32'h2010_0001, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 1'b1, 32'h1, 32'h0, 1'b1);
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hC000_0000, 1'b0);
        cycle(1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1, 32'hC000_0001, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3, 32'hC000_0003, 1'b0);
        cycle(1'b1, 32'h13, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, DA, 1'b0, 1'b1, 32'h8, DW, 1'b0);

        // Build starve count to 3, grant fetch again, then reset mid-cycle.
        repeat (4) cycle(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        #2 rst_n = 1'b0;
        #2 chk_reset_outs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Counter must restart at 0: fetch x4, debug x1, twice.
        apply(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        repeat (3) cycle(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        cycle(1'b1, FA, 1'b1, DA, 1'b0, 1'b1, 32'h8, DW, 1'b0);
        repeat (4) cycle(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        cycle(1'b1, FA, 1'b1, DA, 1'b0, 1'b1, 32'h8, DW, 1'b0);

        // Drop debug at count 3; it then needs 4 more lost cycles.
        repeat (3) cycle(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        cycle(1'b1, FA, 1'b0, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        repeat (4) cycle(1'b1, FA, 1'b1, DA, 1'b1, 1'b0, 32'h4, FW, 1'b0);
        cycle(1'b1, FA, 1'b1, DA, 1'b0, 1'b1, 32'h8, DW, 1'b0);

        cycle(1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2, 32'h2010_0001, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("if_queue_drained", 32'(q_if.size()), 32'd0);
        chk("dbg_queue_drained", 32'(q_dbg.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
